// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The step counter must hold the value WIDTH, hence clog2(WIDTH+1) bits.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in one dividend bit,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem, dvd_msb};
   assign trial   = shifted - {1'b0, dsr};

   // rem < dsr always holds, so a non-negative trial always fits in WIDTH bits
   assign q_bit    = ~trial[WIDTH];
   assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with optional
// two's-complement operands and a start/busy/done handshake.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dsr_r;
   logic [CW-1:0]    cnt;
   logic             sign_q;
   logic             sign_r;
   logic             zero_flag;

   logic             is_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic             load;
   logic             load_zero;
   logic             step_en;
   logic             finish;

   // MIN has no positive counterpart, but its bit pattern is the correct unsigned magnitude
   assign is_signed = SIGNED_EN && signed_mode;
   assign a_neg     = is_signed & dividend[WIDTH-1];
   assign b_neg     = is_signed & divisor[WIDTH-1];
   assign a_mag     = a_neg ? -dividend : dividend;
   assign b_mag     = b_neg ? -divisor  : divisor;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_r),
      .dvd_msb  (dvd_r[WIDTH-1]),
      .dsr      (dsr_r),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? FIX : CALC;
         CALC:    if (cnt == CW'(1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load      = 1'b0;
      load_zero = 1'b0;
      step_en   = 1'b0;
      finish    = 1'b0;
      busy      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start) begin
               if (divisor == '0) load_zero = 1'b1;
               else               load      = 1'b1;
            end
         end
         CALC:    step_en = 1'b1;
         FIX:     finish  = 1'b1;
         default: ;
      endcase
   end

   // dvd_r shifts out dividend bits at the top while quotient bits fill in at the bottom
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r       <= '0;
         dvd_r       <= '0;
         dsr_r       <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero_flag   <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            rem_r     <= '0;
            dvd_r     <= a_mag;
            dsr_r     <= b_mag;
            sign_q    <= a_neg ^ b_neg;
            sign_r    <= a_neg;
            zero_flag <= 1'b0;
            cnt       <= CW'(WIDTH);
         end else if (load_zero) begin
            dvd_r     <= dividend;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_flag <= 1'b1;
         end else if (step_en) begin
            rem_r <= step_rem;
            dvd_r <= {dvd_r[WIDTH-2:0], step_q};
            cnt   <= cnt - CW'(1);
         end

         if (finish) begin
            if (zero_flag) begin
               quotient  <= '1;
               remainder <= dvd_r;
            end else begin
               quotient  <= sign_q ? -dvd_r : dvd_r;
               remainder <= sign_r ? -rem_r : rem_r;
            end
            div_by_zero <= zero_flag;
         end
      end
   end

endmodule
